ulpi_rx_buffer: RTL
===================

# ulpi_rx_buffer

Receive-side stage between the ULPI PHY pins (usb_in/dir/nxt) and the packet decoder in `top`. It decodes PHY-driven bus cycles into RX CMD updates and packet data bytes. Each packet's final byte is tagged, and bytes are buffered in a small FIFO with a valid/ready handshake toward the downstream decoder. All ULPI inputs are synchronous to `clk`; crossing from `ulpi_clk` is handled upstream of this block.

## Interface
- DEPTH, 4, FIFO entries (power of two, ≥2); each entry is {last, data[7:0]}
- clk  input  1  system clock, all state on rising edge
- n_rst  input  1  asynchronous active-low reset
- usb_in  input  8  ULPI data bus as driven by PHY
- dir  input  1  ULPI dir; 1 = PHY owns bus
- nxt  input  1  ULPI nxt
- rx_ready  input  1  downstream accepts head byte this cycle
- rx_data  output  8  FIFO head byte
- rx_last  output  1  head byte is last byte of packet
- rx_valid  output  1  FIFO non-empty
- rx_active  output  1  packet reception in progress
- line_state  output  2  LineState from most recent RX CMD
- rx_err  output  1  one-cycle pulse: RX CMD reported RxError
- overflow  output  1  one-cycle pulse: byte dropped, FIFO full

## Operation
- Bus FSM, states IDLE, TURN, RECV:
  - IDLE: dir=1 → TURN; usb_in ignored.
  - TURN: single turnaround cycle; usb_in ignored. If nxt=1 this cycle, set rx_active. dir=1 → RECV, dir=0 → IDLE.
  - RECV: dir=1 & nxt=1 → data byte; dir=1 & nxt=0 → RX CMD; dir=0 → IDLE (turnaround, usb_in ignored).
- RX CMD decode:
  - line_state ← usb_in[1:0].
  - RxEvent=usb_in[5:4]: 01 or 11 sets rx_active; 00 or 10 clears it.
  - 11 pulses rx_err on the following cycle.
- Staging register (one byte + full flag) holds the newest data byte:
  - Data byte, stage empty: load stage.
  - Data byte, stage full: push staged byte with last=0, load new byte.
  - End of packet: push staged byte with last=1, clear stage and rx_active. End of packet is either of these while rx_active=1: an RX CMD with RxEvent 00/10, or dir sampled 0 in RECV.
  - End of packet with stage empty: no push; rx_active still clears.
- FIFO: push at tail, pop when rx_valid & rx_ready.
  - Push and pop in the same cycle is always legal, including when full.
  - Push when full without pop: entry discarded, FIFO unchanged, overflow pulses next cycle. The stage still advances normally.
  - rx_ready with FIFO empty: no effect.
- Reset, asynchronous:
  - FSM → IDLE; FIFO and stage empty.
  - rx_valid, rx_last, rx_active, rx_err, overflow = 0; line_state = 00; rx_data = 0x00.
  - Reset mid-packet discards all buffered bytes.

## Timing
- rx_data/rx_last/rx_valid come directly from FIFO head registers and count; no combinational path from ULPI inputs.
- Non-last byte sampled at edge N: visible at FIFO head no earlier than the edge after the next data byte is sampled.
- Last byte: visible at head one cycle after the end-of-packet cycle is sampled (FIFO previously empty).
- line_state and rx_active update one cycle after the RX CMD cycle. rx_err and overflow assert for exactly one cycle.
- Pop takes effect at the edge where rx_valid & rx_ready; the next head appears the following cycle.
- Back-to-back data every cycle sustains one push per cycle; one byte of latency comes from staging.

## Test plan
- Reset mid-stream with rx_active=1 and FIFO holding 2 entries → all outputs 0, line_state 00 immediately, no bytes delivered afterward.
- dir rises with nxt=1, then data A5, 3C, 7E (nxt=1), then RX CMD 0x01 → rx_active=1 during packet; FIFO delivers A5/last=0, 3C/last=0, 7E/last=1; rx_active=0; line_state=01.
- Turnaround cycle with usb_in=FF, nxt=0, then RX CMD 0x12 → line_state=10, rx_active=1, no FIFO push; FF never appears.
- rx_ready held 0; packet of DEPTH+2 bytes then dir drop → first DEPTH bytes retained, overflow pulses once per dropped entry, head=first byte.
- RX CMD 0x31 mid-packet then dir=0 → rx_err one-cycle pulse, line_state=01, staged byte pushed with last=1, rx_active=0.
- FIFO full, rx_ready=1 and push in same cycle → no overflow, count stays DEPTH, order preserved.

Source files
------------

// File: rtl/ulpi_rx_buffer.sv
// rtl/ulpi_rx_buffer.sv - ULPI receive decode with last-byte staging and a small output FIFO
module ulpi_rx_buffer #(
    parameter int DEPTH = 4
) (
    input  logic       clk,
    input  logic       n_rst,
    input  logic [7:0] usb_in,
    input  logic       dir,
    input  logic       nxt,
    input  logic       rx_ready,
    output logic [7:0] rx_data,
    output logic       rx_last,
    output logic       rx_valid,
    output logic       rx_active,
    output logic [1:0] line_state,
    output logic       rx_err,
    output logic       overflow
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

    typedef enum logic [1:0] {IDLE, TURN, RECV} state_t;

    state_t state, state_next;

    logic       turn_nxt, data_cyc, cmd_cyc, dir_drop;
    logic       eop;
    logic [7:0] stage_data;
    logic       stage_full;
    logic       push;
    logic [8:0] push_entry;
    logic       pop, fifo_full, do_write;

    logic [8:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0]   count;

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) state <= IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    state_next = dir ? TURN : IDLE;
            TURN:    state_next = dir ? RECV : IDLE;
            RECV:    state_next = dir ? RECV : IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        turn_nxt = 1'b0;
        data_cyc = 1'b0;
        cmd_cyc  = 1'b0;
        dir_drop = 1'b0;
        case (state)
            TURN: turn_nxt = nxt;
            RECV: begin
                data_cyc = dir & nxt;
                cmd_cyc  = dir & ~nxt;
                dir_drop = ~dir;
            end
            default: ;
        endcase
    end

    // RxEvent bit 4 distinguishes "receiving" (01/11) from "not receiving" (00/10)
    assign eop = rx_active & ((cmd_cyc & ~usb_in[4]) | dir_drop);

    always_comb begin
        push       = 1'b0;
        push_entry = {1'b0, stage_data};
        if (data_cyc && stage_full) begin
            push = 1'b1;
        end else if (eop && stage_full) begin
            push       = 1'b1;
            push_entry = {1'b1, stage_data};
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            rx_active  <= 1'b0;
            line_state <= 2'b00;
            rx_err     <= 1'b0;
            stage_data <= 8'h00;
            stage_full <= 1'b0;
        end else begin
            rx_err <= cmd_cyc & (usb_in[5:4] == 2'b11);
            if (turn_nxt)
                rx_active <= 1'b1;
            else if (cmd_cyc)
                rx_active <= usb_in[4];
            else if (dir_drop)
                rx_active <= 1'b0;
            if (cmd_cyc)
                line_state <= usb_in[1:0];
            if (data_cyc) begin
                stage_data <= usb_in;
                stage_full <= 1'b1;
            end else if (eop) begin
                stage_full <= 1'b0;
            end
        end
    end

    assign rx_valid  = (count != '0);
    assign fifo_full = (count == FULL_CNT);
    assign pop       = rx_valid & rx_ready;
    // When full, a simultaneous pop frees the head slot, which is exactly where the tail points
    assign do_write  = push & (~fifo_full | pop);

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= 9'h000;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            overflow <= push & ~do_write;
            if (do_write) begin
                mem[wr_ptr] <= push_entry;
                wr_ptr      <= wr_ptr + AW'(1);
            end
            if (pop)
                rd_ptr <= rd_ptr + AW'(1);
            if (do_write && !pop)
                count <= count + (AW + 1)'(1);
            else if (pop && !do_write)
                count <= count - (AW + 1)'(1);
        end
    end

    assign rx_data = mem[rd_ptr][7:0];
    assign rx_last = mem[rd_ptr][8];

endmodule
